bb_reset_sequencer: RTL and testbench



---
 rtl/bb_reset_sequencer.sv | 168 ++++++++++++++++
 tb/tb_bb_reset_sequencer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/bb_reset_sequencer.sv
// rtl/bb_reset_sequencer.sv - staged, in-order reset release with ready handshake and fault/abort reassert
// Optional WAIT_RDY timeout is compiled in with BB_RSTSEQ_TIMEOUT_EN.
module bb_reset_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DLY   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 8
) (
    input  logic                  bb_clk_in,
    input  logic                  bb_rst_in,
    input  logic                  bb_start_in,
    input  logic [NUM_STAGES-1:0] stage_rdy_in,
    output logic [NUM_STAGES-1:0] stage_rst_out,
    output logic                  seq_done_out,
    output logic                  seq_err_out,
    output logic [2:0]            seq_state_out
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WAIT_DLY = 3'd1;
    localparam logic [2:0] ST_WAIT_RDY = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
    localparam logic [2:0] ST_ERROR    = 3'd4;

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] DLY_LOAD = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STAGES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [2:0]             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_STAGES-1:0]  rst_q, rst_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   start_s;
    logic                   rdy_cur;
    logic                   all_rdy;
    logic                   active;

    assign start_s = sync_q[SYNC_STAGES-1];
    assign rdy_cur = stage_rdy_in[idx_q];
    assign all_rdy = &stage_rdy_in;
    assign active  = (state_q == ST_WAIT_DLY) || (state_q == ST_WAIT_RDY) || (state_q == ST_DONE);

`ifndef BB_RSTSEQ_TIMEOUT_EN
    logic [CNT_W-1:0] unused_timeout;
    assign unused_timeout = TO_LAST;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        done_d  = done_q;
        err_d   = err_q;
        // Abort outranks any release or ready accept on the same edge.
        if (active && !start_s) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            cnt_d   = '0;
            rst_d   = '1;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rst_d  = '1;
                    idx_d  = '0;
                    cnt_d  = '0;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    if (start_s) begin
                        state_d = ST_WAIT_DLY;
                        cnt_d   = DLY_LOAD;
                    end
                end
                ST_WAIT_DLY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        rst_d[idx_q] = 1'b0;
                        cnt_d        = '0;
                        state_d      = ST_WAIT_RDY;
                    end
                end
                ST_WAIT_RDY: begin
                    if (rdy_cur) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            cnt_d   = DLY_LOAD;
                            state_d = ST_WAIT_DLY;
                        end
                    end
`ifdef BB_RSTSEQ_TIMEOUT_EN
                    else if (cnt_q == TO_LAST) begin
                        state_d = ST_ERROR;
                        rst_d   = '1;
                        done_d  = 1'b0;
                        err_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    if (!all_rdy) begin
                        state_d = ST_ERROR;
                        rst_d   = '1;
                        done_d  = 1'b0;
                        err_d   = 1'b1;
                    end
                end
                ST_ERROR: begin
                    rst_d  = '1;
                    done_d = 1'b0;
                    err_d  = 1'b1;
                    // Leaving ERROR requires start low, so a retry needs a fresh rising edge.
                    if (!start_s) begin
                        state_d = ST_IDLE;
                        err_d   = 1'b0;
                        idx_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    cnt_d   = '0;
                    rst_d   = '1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge bb_clk_in) begin
        if (bb_rst_in) begin
            sync_q  <= '0;
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            rst_q   <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], bb_start_in};
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign stage_rst_out = rst_q;
    assign seq_done_out  = done_q;
    assign seq_err_out   = err_q;
    assign seq_state_out = state_q;

endmodule

// File: tb/tb_bb_reset_sequencer.sv
// tb/tb_bb_reset_sequencer.sv - scoreboard bench for bb_reset_sequencer
module tb_bb_reset_sequencer;

    logic       clk;
    logic       bb_rst;
    logic       bb_start;
    logic [3:0] stage_rdy;
    logic [3:0] rdy_kill;
    logic [3:0] stage_rst;
    logic       seq_done;
    logic       seq_err;
    logic [2:0] seq_state;

    bb_reset_sequencer dut (
        .bb_clk_in     (clk),
        .bb_rst_in     (bb_rst),
        .bb_start_in   (bb_start),
        .stage_rdy_in  (stage_rdy),
        .stage_rst_out (stage_rst),
        .seq_done_out  (seq_done),
        .seq_err_out   (seq_err),
        .seq_state_out (seq_state)
    );

    // Subsystems acknowledge as soon as their reset is released, unless masked.
    assign stage_rdy = ~stage_rst & ~rdy_kill;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        string      tag;
        logic [3:0] rst;
        logic       done;
        logic       err;
        logic [2:0] st;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    function automatic void push(input int c, input string tag, input logic [3:0] r,
                                 input logic d, input logic e, input logic [2:0] s);
        exp_t x;
        x.cyc = c; x.tag = tag; x.rst = r; x.done = d; x.err = e; x.st = s;
        sb.push_back(x);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        cyc = cyc + 1;
        #1;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_cmp = n_cmp + 1;
            if (e.cyc < cyc) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: stale entry for cyc %0d seen at cyc %0d", e.tag, e.cyc, cyc);
            end else if ({stage_rst, seq_done, seq_err, seq_state} !== {e.rst, e.done, e.err, e.st}) begin
                n_bad = n_bad + 1;
                $display("FAIL %s @cyc %0d: got rst=%b done=%b err=%b st=%0d, expected rst=%b done=%b err=%b st=%0d",
                         e.tag, cyc, stage_rst, seq_done, seq_err, seq_state, e.rst, e.done, e.err, e.st);
            end
        end
    end

    task automatic at_neg(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    initial begin
        #100000;
        n_cmp = n_cmp + 1;
        n_bad = n_bad + 1;
        $display("FAIL watchdog: stimulus did not complete, cyc=%0d", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        exp_t e;
        bb_rst   = 1'b1;
        bb_start = 1'b1;
        rdy_kill = 4'b0000;

        // Reset held three edges with start high
        push(1, "rst1", 4'b1111, 0, 0, 3'd0);
        push(2, "rst2", 4'b1111, 0, 0, 3'd0);
        push(3, "rst3", 4'b1111, 0, 0, 3'd0);
        at_neg(3);
        bb_rst = 1'b0;

        // Nominal sequence: edge n of the sequence is cyc 3+n
        push(5,  "idle_sync",  4'b1111, 0, 0, 3'd0);
        push(6,  "enter_dly",  4'b1111, 0, 0, 3'd1);
        push(21, "pre_rel0",   4'b1111, 0, 0, 3'd1);
        push(22, "rel0",       4'b1110, 0, 0, 3'd2);
        push(23, "acc0",       4'b1110, 0, 0, 3'd1);
        push(39, "rel1",       4'b1100, 0, 0, 3'd2);
        push(56, "rel2",       4'b1000, 0, 0, 3'd2);
        push(73, "rel3",       4'b0000, 0, 0, 3'd2);
        push(74, "done",       4'b0000, 1, 0, 3'd3);
        push(75, "done_hold",  4'b0000, 1, 0, 3'd3);
        at_neg(80);

        // Ready loss in DONE, then start low clears the error
        rdy_kill = 4'b0100;
        push(81, "rdyloss_err",  4'b1111, 0, 1, 3'd4);
        push(82, "err_stay",     4'b1111, 0, 1, 3'd4);
        at_neg(81);
        rdy_kill = 4'b0000;
        at_neg(82);
        bb_start = 1'b0;
        push(84, "err_hold",   4'b1111, 0, 1, 3'd4);
        push(85, "err_clear",  4'b1111, 0, 0, 3'd0);
        at_neg(90);

        // Abort while waiting on stage 2 ready
        rdy_kill = 4'b0100;
        bb_start = 1'b1;
        push(92,  "ab_idle",   4'b1111, 0, 0, 3'd0);
        push(93,  "ab_dly",    4'b1111, 0, 0, 3'd1);
        push(109, "ab_rel0",   4'b1110, 0, 0, 3'd2);
        push(126, "ab_rel1",   4'b1100, 0, 0, 3'd2);
        push(143, "ab_rel2",   4'b1000, 0, 0, 3'd2);
        push(150, "ab_wait2",  4'b1000, 0, 0, 3'd2);
        at_neg(150);
        bb_start = 1'b0;
        push(152, "abort_pre", 4'b1000, 0, 0, 3'd2);
        push(153, "abort",     4'b1111, 0, 0, 3'd0);
        at_neg(155);
        rdy_kill = 4'b0000;
        at_neg(160);

        // Stage 1 never acknowledges; WAIT_RDY entered at cyc 196
        rdy_kill = 4'b0010;
        bb_start = 1'b1;
        push(179, "to_rel0",   4'b1110, 0, 0, 3'd2);
        push(180, "to_acc0",   4'b1110, 0, 0, 3'd1);
        push(196, "to_rel1",   4'b1100, 0, 0, 3'd2);
`ifdef BB_RSTSEQ_TIMEOUT_EN
        push(450, "to_pre",    4'b1100, 0, 0, 3'd2);
        push(451, "to_fire",   4'b1111, 0, 1, 3'd4);
`else
        push(451, "no_to_255", 4'b1100, 0, 0, 3'd2);
        push(1196, "no_to_1000", 4'b1100, 0, 0, 3'd2);
`endif
        at_neg(1200);

        // One-edge reset, then a reset pulse during stage 3 delay
        bb_rst   = 1'b1;
        bb_start = 1'b0;
        rdy_kill = 4'b0000;
        push(1201, "rst_pulse", 4'b1111, 0, 0, 3'd0);
        at_neg(1201);
        bb_rst   = 1'b0;
        bb_start = 1'b1;
        push(1220, "m_rel0",     4'b1110, 0, 0, 3'd2);
        push(1237, "m_rel1",     4'b1100, 0, 0, 3'd2);
        push(1254, "m_rel2",     4'b1000, 0, 0, 3'd2);
        push(1255, "m_dly3",     4'b1000, 0, 0, 3'd1);
        push(1259, "pre_midrst", 4'b1000, 0, 0, 3'd1);
        at_neg(1259);
        bb_rst = 1'b1;
        push(1260, "midrst",     4'b1111, 0, 0, 3'd0);
        at_neg(1260);
        bb_rst = 1'b0;
        push(1278, "re_pre",     4'b1111, 0, 0, 3'd1);
        push(1279, "re_rel0",    4'b1110, 0, 0, 3'd2);
        at_neg(1285);

        while (sb.size() > 0) begin
            e = sb.pop_front();
            n_cmp = n_cmp + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s: expected entry for cyc %0d never checked", e.tag, e.cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
